// File: rtl/player_move_ctrl.sv
// -----------------------------------------------------------------------------
// player_move_ctrl
//
// Movement scheduler for the player position register. Raw left/right buttons
// are synchronised, arbitrated (first owner holds) and turned into paced,
// frame-synchronous one-clock step pulses with hold-to-repeat: first step on
// the first frame tick after the press, the second REPEAT_DELAY ticks later,
// and then one step every REPEAT_RATE ticks. Steps are gated by the position
// register's boundary-room flags; a gated step still advances the pacing.
//
// Parameters
//   REPEAT_DELAY  frame ticks from first to second step while held (1..255)
//   REPEAT_RATE   frame ticks between later repeated steps        (1..255)
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   frame_tick  in   one-clk pulse per video frame, synchronous to clk
//   enable      in   game running; low forces IDLE and suppresses steps
//   btn_left    in   raw asynchronous left button, active-high
//   btn_right   in   raw asynchronous right button, active-high
//   room_left   in   position register can still move left
//   room_right  in   position register can still move right
//   step_left   out  one-clk pulse: move left one dx
//   step_right  out  one-clk pulse: move right one dx
//   dir_locked  out  {right,left} direction currently owned; 2'b00 in IDLE
//   busy        out  high whenever the scheduler is not IDLE
// -----------------------------------------------------------------------------
module player_move_ctrl #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       room_left,
  input  logic       room_right,
  output logic       step_left,
  output logic       step_right,
  output logic [1:0] dir_locked,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } state_t;

  localparam logic [7:0] DELAY_LAST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] RATE_LAST  = 8'(REPEAT_RATE - 1);

  // Two-flop synchronisers for the raw buttons
  logic btn_left_p0;
  logic btn_left_p1;
  logic btn_right_p0;
  logic btn_right_p1;
  logic bl;
  logic br;

  state_t     state;
  state_t     state_next;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_next;
  logic [1:0] dir;
  logic [1:0] dir_next;
  logic       step_now;
  logic       held;
  logic       abort;
  logic       step_left_next;
  logic       step_right_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_left_p0  <= 1'b0;
      btn_left_p1  <= 1'b0;
      btn_right_p0 <= 1'b0;
      btn_right_p1 <= 1'b0;
    end else begin
      btn_left_p0  <= btn_left;
      btn_left_p1  <= btn_left_p0;
      btn_right_p0 <= btn_right;
      btn_right_p1 <= btn_right_p0;
    end
  end

  assign bl = btn_left_p1;
  assign br = btn_right_p1;

  // dir is one-hot {right,left}, so masking with the synced buttons tells us
  // whether the owning button is still down; the other button is ignored.
  assign held  = |(dir & {br, bl});
  assign abort = (state != IDLE) && (!enable || !held);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      dir       <= 2'b00;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
      dir       <= dir_next;
    end
  end

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    dir_next       = dir;
    step_now       = 1'b0;

    // Abort wins over a coincident frame tick: no step is issued that cycle.
    if (abort) begin
      state_next     = IDLE;
      frame_cnt_next = 8'd0;
      dir_next       = 2'b00;
    end else begin
      case (state)
        IDLE: begin
          frame_cnt_next = 8'd0;
          dir_next       = 2'b00;
          // Both buttons down is a tie: nobody owns the move.
          if (enable && (bl ^ br)) begin
            dir_next   = {br, bl};
            state_next = ARMED;
          end
        end
        ARMED: begin
          if (frame_tick) begin
            step_now       = 1'b1;
            frame_cnt_next = 8'd0;
            state_next     = DELAY;
          end
        end
        DELAY: begin
          if (frame_tick) begin
            if (frame_cnt == DELAY_LAST) begin
              step_now       = 1'b1;
              frame_cnt_next = 8'd0;
              state_next     = REPEAT;
            end else begin
              frame_cnt_next = frame_cnt + 8'd1;
            end
          end
        end
        REPEAT: begin
          if (frame_tick) begin
            if (frame_cnt == RATE_LAST) begin
              step_now       = 1'b1;
              frame_cnt_next = 8'd0;
            end else begin
              frame_cnt_next = frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_next     = IDLE;
          frame_cnt_next = 8'd0;
          dir_next       = 2'b00;
        end
      endcase
    end
  end

  // Room is sampled in the tick cycle; a blocked step still consumed the tick.
  assign step_left_next  = step_now & dir[0] & room_left;
  assign step_right_next = step_now & dir[1] & room_right;

  // Outputs registered from the next-state view so busy/dir_locked line up
  // with the state register and the step lands the cycle after its tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_left  <= 1'b0;
      step_right <= 1'b0;
      dir_locked <= 2'b00;
      busy       <= 1'b0;
    end else begin
      step_left  <= step_left_next;
      step_right <= step_right_next;
      dir_locked <= dir_next;
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_move_ctrl
//
// Self-checking bench for player_move_ctrl (REPEAT_DELAY=8, REPEAT_RATE=2).
// A behavioural model tracks the owning button and the number of frame ticks
// seen since it was armed; a step is earned on tick 1, tick 1+D and every R
// ticks after that. Directed scenarios also check pulse positions by tick
// number.
// -----------------------------------------------------------------------------
module tb_player_move_ctrl;

  localparam int D = 8;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       enable;
  logic       btn_left;
  logic       btn_right;
  logic       room_left;
  logic       room_right;
  logic       step_left;
  logic       step_right;
  logic [1:0] dir_locked;
  logic       busy;
  logic [4:0] act;

  int checks = 0;
  int errors = 0;

  // Model state: synchroniser delay line, owner (0 none, 1 left, 2 right),
  // ticks counted since arming, and the expected step pulses.
  logic m_s1l, m_bl, m_s1r, m_br;
  int   owner;
  int   nticks;
  logic e_sl, e_sr;

  always #5 clk = ~clk;

  player_move_ctrl #(
    .REPEAT_DELAY(D),
    .REPEAT_RATE (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .enable    (enable),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .room_left (room_left),
    .room_right(room_right),
    .step_left (step_left),
    .step_right(step_right),
    .dir_locked(dir_locked),
    .busy      (busy)
  );

  assign act = {step_left, step_right, busy, dir_locked};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit earns_step(int k);
    return (k == 1) || (k == 1 + D) || ((k > 1 + D) && (((k - 1 - D) % R) == 0));
  endfunction

  function automatic logic [4:0] exp_vec();
    logic [1:0] d;
    d = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    return {e_sl, e_sr, (owner != 0), d};
  endfunction

  task automatic model_update();
    logic lvl;
    e_sl = 1'b0;
    e_sr = 1'b0;
    if (reset) begin
      m_s1l = 0; m_bl = 0; m_s1r = 0; m_br = 0;
      owner = 0; nticks = 0;
      return;
    end
    if (owner != 0) begin
      lvl = (owner == 1) ? m_bl : m_br;
      if (!enable || !lvl) begin
        owner  = 0;
        nticks = 0;
      end else if (frame_tick) begin
        nticks++;
        if (earns_step(nticks)) begin
          e_sl = (owner == 1) && room_left;
          e_sr = (owner == 2) && room_right;
        end
      end
    end else if (enable && (m_bl != m_br)) begin
      owner  = m_bl ? 1 : 2;
      nticks = 0;
    end
    m_bl  = m_s1l; m_s1l = btn_left;
    m_br  = m_s1r; m_s1r = btn_right;
  endtask

  // Advance one clock: the model consumes the inputs present at the edge,
  // then outputs are sampled 1 time unit later.
  task automatic clk_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    frame_tick = 0; btn_left = 0; btn_right = 0;
    enable = 1; room_left = 1; room_right = 1;
  endtask

  task automatic settle(int n);
    idle_inputs();
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    clk_cycle();
    clk_cycle();
    if (act !== 5'b00000) begin
      errors++; $display("FAIL reset_state got=%b exp=%b", act, 5'b00000);
    end
    checks++;
    reset = 0;
    clk_cycle();
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", act, exp_vec());
    end
    checks++;
  endtask

  task automatic test_tap();
    int nl = 0, nr = 0;
    idle_inputs();
    btn_left = 1;
    for (int c = 0; c < 24; c++) begin
      if (c == 7) btn_left = 0;
      frame_tick = (c % 6 == 5);
      clk_cycle();
      nl += step_left; nr += step_right;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL tap cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (nl != 1 || nr != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL tap_count left=%0d right=%0d busy=%b exp 1 0 0", nl, nr, busy);
    end
    checks++;
    settle(4);
  endtask

  task automatic test_hold_right();
    int rec[$];
    int exp_t[7] = '{1, 9, 11, 13, 15, 17, 19};
    int tn = 0;
    idle_inputs();
    btn_right = 1;
    for (int c = 0; c < 120; c++) begin
      frame_tick = (c % 6 == 5);
      if (frame_tick) tn++;
      clk_cycle();
      if (step_right) rec.push_back(tn);
      if (act !== exp_vec()) begin
        errors++; $display("FAIL hold_right cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (rec.size() != 7) begin
      errors++; $display("FAIL hold_right_count got=%0d exp=7", rec.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (rec[i] != exp_t[i]) begin
          errors++; $display("FAIL hold_right_tick idx=%0d got=%0d exp=%0d", i, rec[i], exp_t[i]);
        end
        checks++;
      end
    end
    checks++;
    settle(6);
  endtask

  task automatic test_room();
    int rec[$];
    int exp_t[5] = '{11, 13, 15, 17, 19};
    int tn = 0;
    idle_inputs();
    room_right = 0;
    btn_right  = 1;
    for (int c = 0; c < 120; c++) begin
      frame_tick = (c % 6 == 5);
      if (frame_tick) tn++;
      if (tn == 11) room_right = 1;
      clk_cycle();
      if (step_right || step_left) rec.push_back(tn);
      if (c == 40 && (busy !== 1'b1 || dir_locked !== 2'b10)) begin
        errors++; $display("FAIL room_blocked busy=%b dir=%b exp 1 10", busy, dir_locked);
      end
      if (act !== exp_vec()) begin
        errors++; $display("FAIL room cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    checks++;
    if (rec.size() != 5) begin
      errors++; $display("FAIL room_count got=%0d exp=5", rec.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (rec[i] != exp_t[i]) begin
          errors++; $display("FAIL room_tick idx=%0d got=%0d exp=%0d", i, rec[i], exp_t[i]);
        end
        checks++;
      end
    end
    checks++;
    settle(6);
  endtask

  task automatic test_tie_and_arb();
    int ns = 0, nb = 0, nr = 0, nl = 0;
    int rec[$];
    int tn = 0;
    idle_inputs();
    btn_left = 1; btn_right = 1;
    for (int c = 0; c < 30; c++) begin
      frame_tick = (c % 6 == 5);
      clk_cycle();
      ns += step_left + step_right; nb += busy;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL tie cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (ns != 0 || nb != 0) begin
      errors++; $display("FAIL tie_quiet steps=%0d busy_cycles=%0d exp 0 0", ns, nb);
    end
    checks++;
    settle(4);
    // Left owns first; right pressed later is ignored until left releases.
    btn_left = 1;
    for (int c = 0; c < 36; c++) begin
      if (c == 18) btn_right = 1;
      frame_tick = (c % 6 == 5);
      clk_cycle();
      nl += step_left; nr += step_right;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL arb_hold cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (nr != 0 || nl != 1) begin
      errors++; $display("FAIL arb_owner left=%0d right=%0d exp 1 0", nl, nr);
    end
    checks++;
    btn_left = 0;
    for (int c = 0; c < 60; c++) begin
      frame_tick = (c % 6 == 5);
      if (frame_tick) tn++;
      clk_cycle();
      if (step_right) rec.push_back(tn);
      if (act !== exp_vec()) begin
        errors++; $display("FAIL arb_handover cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (rec.size() != 2 || rec[0] != 1 || rec[1] != 9) begin
      errors++; $display("FAIL arb_handover_ticks got_n=%0d first=%0d exp n=2 ticks 1,9",
                         rec.size(), (rec.size() > 0) ? rec[0] : -1);
    end
    checks++;
    settle(6);
  endtask

  task automatic test_reset_mid();
    int first = -1;
    idle_inputs();
    btn_right = 1;
    for (int c = 0; c < 66; c++) begin
      frame_tick = (c % 6 == 5);
      clk_cycle();
    end
    frame_tick = 1;
    reset = 1;
    #1;
    if (act !== 5'b00000) begin
      errors++; $display("FAIL reset_mid_immediate got=%b exp=%b", act, 5'b00000);
    end
    checks++;
    clk_cycle();
    frame_tick = 0;
    clk_cycle();
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      frame_tick = (c == 5);
      clk_cycle();
      if (step_right && first < 0) first = c;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL reset_mid_restart cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (first != 5) begin
      errors++; $display("FAIL reset_mid_first got=%0d exp=5", first);
    end
    checks++;
    settle(6);
  endtask

  task automatic test_enable_drop();
    int nl_off = 0, nl_on = 0;
    idle_inputs();
    btn_left = 1;
    for (int c = 0; c < 48; c++) begin
      if (c == 24) enable = 0;
      frame_tick = (c % 6 == 5);
      clk_cycle();
      if (c >= 24) nl_off += step_left;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL enable_drop cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (nl_off != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL enable_off steps=%0d busy=%b exp 0 0", nl_off, busy);
    end
    checks++;
    enable = 1;
    for (int c = 0; c < 6; c++) begin
      frame_tick = (c == 5);
      clk_cycle();
      nl_on += step_left;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL enable_rearm cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    if (nl_on != 1) begin
      errors++; $display("FAIL enable_rearm_step got=%0d exp=1", nl_on);
    end
    checks++;
    settle(6);
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 11) == 0) btn_left   = ~btn_left;
      if ($urandom_range(0, 11) == 0) btn_right  = ~btn_right;
      if ($urandom_range(0, 60) == 0) enable     = ~enable;
      if ($urandom_range(0, 20) == 0) room_left  = ~room_left;
      if ($urandom_range(0, 20) == 0) room_right = ~room_right;
      frame_tick = ($urandom_range(0, 3) == 0);
      clk_cycle();
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", c, act, exp_vec());
      end
      checks++;
    end
    settle(6);
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_s1l = 0; m_bl = 0; m_s1r = 0; m_br = 0;
    owner = 0; nticks = 0; e_sl = 0; e_sr = 0;
    test_reset();
    test_tap();
    test_hold_right();
    test_room();
    test_tie_and_arb();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
